serial_fullsubtractor_seq: RTL and testbench



---
 rtl/serial_fullsubtractor_seq.sv | 142 ++++++++++++++
 tb/tb_serial_fullsubtractor_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_fullsubtractor_seq.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to build the signed-overflow flag; otherwise ovf is tied to 0.
module serial_fullsubtractor_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             done_reg;
    logic             bit_d;
    logic             bit_bo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bit_d      = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
        bit_bo     = (~a_sh_reg[0] & b_sh_reg[0]) | (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            br_reg     <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            // The completion pulse and result are registered on the edge leaving DONE.
            done_reg <= (state_reg == S_DONE);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        a_sh_reg <= a;
                        b_sh_reg <= b;
                        br_reg   <= bin;
                        cnt_reg  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    res_sh_reg <= {bit_d, res_sh_reg[WIDTH-1:1]};
                    br_reg     <= bit_bo;
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                S_DONE: begin
                    diff_reg <= res_sh_reg;
                    bout_reg <= br_reg;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start) begin
                a_msb_reg <= a[WIDTH-1];
                b_msb_reg <= b[WIDTH-1];
            end
            if (state_reg == S_DONE) begin
                ovf_reg <= (a_msb_reg ^ b_msb_reg) & (a_msb_reg ^ res_sh_reg[WIDTH-1]);
            end
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_fullsubtractor_seq.sv
// Self-checking bench for serial_fullsubtractor_seq: directed WIDTH=8 vectors,
// handshake corner cases, async reset abort, and exhaustive WIDTH=2 sweep.
module tb_serial_fullsubtractor_seq;

`ifdef SERIAL_SUB_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, bout2, ovf2;
    logic [1:0] a2, b2, diff2;

    int n_checks = 0;
    int n_fail   = 0;

    serial_fullsubtractor_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_fullsubtractor_seq #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with dut8 idle; returns at the negedge where done is seen.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                       input logic [7:0] ed, input logic eb, input logic eo, input string tag);
        int edges;
        int busy_n;
        int got;
        a8 = ta; b8 = tbv; bin8 = tbin; start8 = 1'b1;
        @(posedge clk);
        edges = 1; busy_n = 0; got = 0;
        @(negedge clk);
        start8 = 1'b0;
        chk({tag, "_accept_busy"}, 32'(busy8), 32'd1);
        chk({tag, "_accept_done"}, 32'(done8), 32'd0);
        while (got == 0 && edges < 40) begin
            if (busy8) busy_n++;
            if (done8) got = 1;
            else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(edges), 32'd10);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd9);
        chk({tag, "_diff"}, 32'(diff8), 32'(ed));
        chk({tag, "_bout"}, 32'(bout8), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf8), 32'(OVF_EN ? eo : 1'b0));
        $display("op8 %s: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ovf=%0d lat=%0d",
                 tag, ta, tbv, tbin, diff8, bout8, ovf8, edges);
    endtask

    task automatic op2(input logic [1:0] ta, input logic [1:0] tbv, input logic tbin);
        int r;
        int cycles;
        logic [1:0] ed;
        logic eb, eo;
        r  = int'(ta) - int'(tbv) - int'(tbin);
        ed = 2'(r & 3);
        eb = (r < 0);
        eo = OVF_EN ? ((ta[1] ^ tbv[1]) & (ta[1] ^ ed[1])) : 1'b0;
        a2 = ta; b2 = tbv; bin2 = tbin; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cycles = 0;
        while (!done2 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk("w2_done_seen", 32'(done2), 32'd1);
        chk("w2_diff", 32'(diff2), 32'(ed));
        chk("w2_bout", 32'(bout2), 32'(eb));
        chk("w2_ovf", 32'(ovf2), 32'(eo));
        $display("op2: a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d", ta, tbv, tbin, diff2, bout2, ovf2);
    endtask

    initial begin
        int pulses;
        logic [7:0] seen_diff;
        logic seen_bout;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 8'h09, 1'b1, 8'hFD, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_diff", 32'(diff8), 32'd0);
        chk("reset_bout", 32'(bout8), 32'd0);
        chk("reset_ovf", 32'(ovf8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, each issued back-to-back in the cycle done is high.
        for (int i = 0; i < 10; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf,
                $sformatf("vec%0d", i));
        end
        @(negedge clk);
        chk("pulse_width_done", 32'(done8), 32'd0);
        chk("idle_busy", 32'(busy8), 32'd0);
        chk("hold_diff", 32'(diff8), 32'h80);

        // start and operand changes while busy are ignored
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h55; bin8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0; seen_diff = '0; seen_bout = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                seen_diff = diff8;
                seen_bout = bout8;
            end
        end
        chk("ignore_pulses", 32'(pulses), 32'd1);
        chk("ignore_diff", 32'(seen_diff), 32'hFF);
        chk("ignore_bout", 32'(seen_bout), 32'd0);
        $display("ignored-start: pulses=%0d diff=%02h bout=%0d", pulses, seen_diff, seen_bout);

        // asynchronous reset mid-SHIFT
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy8), 32'd0);
        chk("async_rst_done", 32'(done8), 32'd0);
        chk("async_rst_diff", 32'(diff8), 32'd0);
        chk("async_rst_bout", 32'(bout8), 32'd0);
        chk("async_rst_ovf", 32'(ovf8), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        $display("async reset: aborted op produced %0d done pulses", pulses);
        op8(8'h07, 8'h09, 1'b1, 8'hFD, 1'b1, 1'b0, "after_rst");
        @(negedge clk);

        // exhaustive WIDTH=2
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    op2(2'(ai), 2'(bi), 1'(ci));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
